// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the SPI register bridge: parser state encodings,
// command byte layout and error codes.
// -----------------------------------------------------------------------------
package spi_reg_pkg;

  // Parser states, kept as plain 3-bit constants so legacy code that compares
  // raw state values keeps working.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CMD     = 3'd1;
  localparam state_t ST_ADDR    = 3'd2;
  localparam state_t ST_WDATA   = 3'd3;
  localparam state_t ST_RD_REQ  = 3'd4;
  localparam state_t ST_RD_WAIT = 3'd5;
  localparam state_t ST_RD_SEND = 3'd6;
  localparam state_t ST_DROP    = 3'd7;

  // Command byte layout.
  localparam int         CMD_RD_BIT   = 7;
  localparam int         CMD_AI_BIT   = 6;
  localparam logic [7:0] CMD_RSV_MASK = 8'h3F;

  // Values reported on err_code.
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_BAD_CMD = 3'd1,
    ERR_SHORT   = 3'd2,
    ERR_RD_TMO  = 3'd3,
    ERR_TX_UDR  = 3'd4
  } err_code_t;

  // A command is rejected when any reserved bit is set.
  function automatic logic cmd_is_bad(input logic [7:0] cmd);
    return (cmd & CMD_RSV_MASK) != 8'h00;
  endfunction

endpackage

// File: rtl/spi_tx_word_shifter.sv
// -----------------------------------------------------------------------------
// spi_tx_word_shifter
// Holds one register word for transmission and hands it out one byte at a
// time, most significant byte first.
//
// Ports:
//   clock, rst_n  system clock, asynchronous active-low reset
//   load          capture load_word and restart at its MSB byte
//   load_word     word to transmit (DATA_BYTES bytes)
//   pop           advance to the next byte
//   cur_byte      byte currently at the head of the word
//   last          cur_byte is the final byte of the word
// -----------------------------------------------------------------------------
module spi_tx_word_shifter
  import spi_reg_pkg::*;
#(
  parameter  int DATA_BYTES = 1,
  localparam int DATA_W     = 8 * DATA_BYTES
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_word,
  input  logic              pop,
  output logic [7:0]        cur_byte,
  output logic              last
);

  localparam logic [7:0] LAST_IDX = 8'(DATA_BYTES - 1);

  logic [DATA_W-1:0] shreg;
  logic [7:0]        idx;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= load_word;
      idx   <= '0;
    end else if (pop) begin
      shreg <= shreg << 8;
      idx   <= last ? 8'd0 : idx + 8'd1;
    end
  end

  assign cur_byte = shreg[DATA_W-1 -: 8];
  assign last     = (idx == LAST_IDX);

endmodule

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
// Decodes framed commands from the SPI slave PHY rx byte stream and turns them
// into register bus writes and reads. Frame: command byte, ADDR_BYTES address
// bytes (MSB first), then either write words (DATA_BYTES each, MSB first) or
// dummy bytes while read data is returned on the tx side.
//
// Ports:
//   clock, rst_n        system clock, asynchronous active-low reset
//   rx_stream_sof/eof   frame start / end pulses (cs_n edges)
//   rx_stream_data/vld  received byte and its one-cycle valid
//   tx_send_flag        PHY asks for the next tx byte
//   tx_send_data/valid  tx byte answering a flag, valid one cycle later
//   tx_empty            PHY tx shifter idle
//   reg_wr / reg_rd     one-cycle register write / read strobes
//   reg_addr/reg_wdata  transaction address and write data
//   reg_rdata/rvalid    read data and its one-cycle valid
//   err_pulse/err_code  one-cycle error pulse and sticky last error code
// -----------------------------------------------------------------------------
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter  int         ADDR_BYTES = 2,
  parameter  int         DATA_BYTES = 1,
  parameter  int         RD_TIMEOUT = 255,
  parameter  logic [7:0] IDLE_BYTE  = 8'hFF,
  localparam int         ADDR_W     = 8 * ADDR_BYTES,
  localparam int         DATA_W     = 8 * DATA_BYTES
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              rx_stream_sof,
  input  logic [7:0]        rx_stream_data,
  input  logic              rx_stream_vld,
  input  logic              rx_stream_eof,
  input  logic              tx_send_flag,
  output logic [7:0]        tx_send_data,
  output logic              tx_send_valid,
  input  logic              tx_empty,
  output logic              reg_wr,
  output logic              reg_rd,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rvalid,
  output logic              err_pulse,
  output logic [2:0]        err_code
);

  localparam logic [7:0]  ADDR_LAST = 8'(ADDR_BYTES - 1);
  localparam logic [7:0]  DATA_LAST = 8'(DATA_BYTES - 1);
  localparam logic [15:0] TMO_LOAD  = 16'(RD_TIMEOUT);

  state_t            state;
  logic [7:0]        byte_cnt;
  logic              cmd_rd;
  logic              cmd_ai;
  logic [DATA_W-1:0] wshift;
  logic [15:0]       tmo_cnt;

  logic              frame_evt;
  logic              rx_byte;
  logic              partial;
  logic              rd_done;
  logic              phy_busy;
  logic              err_short;
  logic              err_bad;
  logic              err_tmo;
  logic              err_udr;
  logic              err_any;
  err_code_t         err_sel;

  logic              tx_load;
  logic [DATA_W-1:0] tx_word;
  logic              tx_pop;
  logic [7:0]        tx_byte;
  logic              tx_last;

  // Frame boundaries pre-empt byte processing; a byte arriving with sof/eof
  // is not part of either frame.
  assign frame_evt = rx_stream_sof | rx_stream_eof;
  assign rx_byte   = rx_stream_vld & ~frame_evt;

  // Any address phase is incomplete by definition; a write phase is only
  // incomplete once part of a word has been shifted in.
  assign partial   = (state == ST_ADDR) || ((state == ST_WDATA) && (byte_cnt != 8'd0));

  // The wait ends on returned data or when the counter is about to hit zero.
  assign rd_done   = ~frame_evt && (state == ST_RD_WAIT) &&
                     (reg_rvalid || (tmo_cnt == 16'd1));

  // A flag always means the PHY is shifting; an idle PHY with no flag never
  // counts as an underrun.
  assign phy_busy  = tx_send_flag | ~tx_empty;

  // With sof and eof together, eof closes the old frame (possibly reporting
  // it short) and sof then opens from IDLE, so one check covers both orders.
  assign err_short = frame_evt & partial;
  assign err_bad   = rx_byte && (state == ST_CMD) && cmd_is_bad(rx_stream_data);
  assign err_tmo   = rd_done && !reg_rvalid;
  assign err_udr   = tx_send_flag && phy_busy &&
                     ((state == ST_RD_REQ) || (state == ST_RD_WAIT));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it holding a value and infer a latch.
    err_any = 1'b0;
    err_sel = ERR_NONE;
    if (err_short) begin
      err_any = 1'b1;
      err_sel = ERR_SHORT;
    end else if (err_bad) begin
      err_any = 1'b1;
      err_sel = ERR_BAD_CMD;
    end else if (err_tmo) begin
      err_any = 1'b1;
      err_sel = ERR_RD_TMO;
    end else if (err_udr) begin
      err_any = 1'b1;
      err_sel = ERR_TX_UDR;
    end
  end

  // A timed-out read returns all-ones so the host sees a recognisable value.
  assign tx_load = rd_done;
  assign tx_word = reg_rvalid ? reg_rdata : {DATA_W{1'b1}};
  assign tx_pop  = tx_send_flag && (state == ST_RD_SEND);

  spi_tx_word_shifter #(
    .DATA_BYTES (DATA_BYTES)
  ) u_tx_shifter (
    .clock     (clock),
    .rst_n     (rst_n),
    .load      (tx_load),
    .load_word (tx_word),
    .pop       (tx_pop),
    .cur_byte  (tx_byte),
    .last      (tx_last)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      byte_cnt      <= '0;
      cmd_rd        <= 1'b0;
      cmd_ai        <= 1'b0;
      wshift        <= '0;
      tmo_cnt       <= '0;
      reg_addr      <= '0;
      reg_wdata     <= '0;
      reg_wr        <= 1'b0;
      reg_rd        <= 1'b0;
      tx_send_data  <= IDLE_BYTE;
      tx_send_valid <= 1'b0;
      err_pulse     <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      reg_wr        <= 1'b0;
      reg_rd        <= 1'b0;
      err_pulse     <= err_any;
      if (err_any) begin
        err_code <= err_sel;
      end

      // Every flag is answered one cycle later: real data only in RD_SEND.
      tx_send_valid <= tx_send_flag;
      if (tx_send_flag) begin
        tx_send_data <= (state == ST_RD_SEND) ? tx_byte : IDLE_BYTE;
      end

      // Advance the burst address after the strobe so reg_addr is stable
      // during the write it belongs to.
      if (reg_wr && cmd_ai) begin
        reg_addr <= reg_addr + 1'b1;
      end

      if (frame_evt) begin
        state    <= rx_stream_sof ? ST_CMD : ST_IDLE;
        byte_cnt <= '0;
      end else begin
        case (state)
          ST_CMD: begin
            if (rx_stream_vld) begin
              cmd_rd   <= rx_stream_data[CMD_RD_BIT];
              cmd_ai   <= rx_stream_data[CMD_AI_BIT];
              byte_cnt <= '0;
              state    <= cmd_is_bad(rx_stream_data) ? ST_DROP : ST_ADDR;
            end
          end

          ST_ADDR: begin
            if (rx_stream_vld) begin
              reg_addr <= ADDR_W'({reg_addr, rx_stream_data});
              if (byte_cnt == ADDR_LAST) begin
                byte_cnt <= '0;
                state    <= cmd_rd ? ST_RD_REQ : ST_WDATA;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end
          end

          ST_WDATA: begin
            if (rx_stream_vld) begin
              wshift <= DATA_W'({wshift, rx_stream_data});
              if (byte_cnt == DATA_LAST) begin
                reg_wdata <= DATA_W'({wshift, rx_stream_data});
                reg_wr    <= 1'b1;
                byte_cnt  <= '0;
              end else begin
                byte_cnt <= byte_cnt + 8'd1;
              end
            end
          end

          ST_RD_REQ: begin
            reg_rd  <= 1'b1;
            tmo_cnt <= TMO_LOAD;
            state   <= ST_RD_WAIT;
          end

          ST_RD_WAIT: begin
            if (rd_done) begin
              state <= ST_RD_SEND;
            end else begin
              tmo_cnt <= tmo_cnt - 1'b1;
            end
          end

          ST_RD_SEND: begin
            // Once the word is drained, prefetch the next (or same) address.
            if (tx_send_flag && tx_last) begin
              if (cmd_ai) begin
                reg_addr <= reg_addr + 1'b1;
              end
              state <= ST_RD_REQ;
            end
          end

          default: begin
            // IDLE and DROP wait for the next frame boundary.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bridge
// Directed bench for spi_reg_bridge. Two instances share the stimulus:
// dut_a (ADDR_BYTES=2, DATA_BYTES=1, RD_TIMEOUT=255) for write-path cases,
// dut_b (ADDR_BYTES=2, DATA_BYTES=2, RD_TIMEOUT=8) for read-path cases.
// -----------------------------------------------------------------------------
module tb_spi_reg_bridge;
  import spi_reg_pkg::*;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        sof, vld, eof, tx_flag, tx_empty, reg_rvalid;
  logic [7:0]  rx_data;
  logic [15:0] reg_rdata;

  logic [7:0]  a_tx_data, b_tx_data;
  logic        a_tx_valid, b_tx_valid;
  logic        a_reg_wr, b_reg_wr, a_reg_rd, b_reg_rd;
  logic [15:0] a_reg_addr, b_reg_addr;
  logic [7:0]  a_reg_wdata;
  logic [15:0] b_reg_wdata;
  logic        a_err_pulse, b_err_pulse;
  logic [2:0]  a_err_code, b_err_code;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  spi_reg_bridge #(.ADDR_BYTES(2), .DATA_BYTES(1), .RD_TIMEOUT(255), .IDLE_BYTE(8'hFF)) dut_a (
    .clock(clock), .rst_n(rst_n),
    .rx_stream_sof(sof), .rx_stream_data(rx_data), .rx_stream_vld(vld), .rx_stream_eof(eof),
    .tx_send_flag(tx_flag), .tx_send_data(a_tx_data), .tx_send_valid(a_tx_valid), .tx_empty(tx_empty),
    .reg_wr(a_reg_wr), .reg_rd(a_reg_rd), .reg_addr(a_reg_addr), .reg_wdata(a_reg_wdata),
    .reg_rdata(reg_rdata[7:0]), .reg_rvalid(reg_rvalid),
    .err_pulse(a_err_pulse), .err_code(a_err_code)
  );

  spi_reg_bridge #(.ADDR_BYTES(2), .DATA_BYTES(2), .RD_TIMEOUT(8), .IDLE_BYTE(8'hFF)) dut_b (
    .clock(clock), .rst_n(rst_n),
    .rx_stream_sof(sof), .rx_stream_data(rx_data), .rx_stream_vld(vld), .rx_stream_eof(eof),
    .tx_send_flag(tx_flag), .tx_send_data(b_tx_data), .tx_send_valid(b_tx_valid), .tx_empty(tx_empty),
    .reg_wr(b_reg_wr), .reg_rd(b_reg_rd), .reg_addr(b_reg_addr), .reg_wdata(b_reg_wdata),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .err_pulse(b_err_pulse), .err_code(b_err_code)
  );

  // Write and error log, sampled mid-cycle.
  int          a_wr_n  = 0;
  int          a_err_n = 0;
  int          b_err_n = 0;
  logic [15:0] a_wr_addr [64];
  logic [7:0]  a_wr_data [64];

  always @(negedge clock) begin
    if (a_reg_wr && a_wr_n < 64) begin
      a_wr_addr[a_wr_n] <= a_reg_addr;
      a_wr_data[a_wr_n] <= a_reg_wdata;
      a_wr_n            <= a_wr_n + 1;
    end
    if (a_err_pulse) a_err_n <= a_err_n + 1;
    if (b_err_pulse) b_err_n <= b_err_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_sof();
    sof = 1'b1; tick(); sof = 1'b0; tick();
  endtask

  task automatic pulse_eof();
    eof = 1'b1; tick(); eof = 1'b0; tick();
  endtask

  // One valid cycle; outputs checked straight after show the reaction.
  task automatic byte_in(input logic [7:0] b);
    rx_data = b; vld = 1'b1; tick(); vld = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_in(b); tick();
  endtask

  task automatic flag_once();
    tx_flag = 1'b1; tick(); tx_flag = 1'b0;
  endtask

  task automatic wait_b_rd(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (b_reg_rd) break;
      tick();
    end
    check(tag, 32'(b_reg_rd), 32'd1);
  endtask

  int wbase, ebase;

  initial begin
    rst_n = 1'b0; sof = 1'b0; vld = 1'b0; eof = 1'b0; tx_flag = 1'b0;
    tx_empty = 1'b1; reg_rvalid = 1'b0; rx_data = 8'h00; reg_rdata = 16'h0000;
    tick(); tick();

    // Reset values.
    check("rst_tx_data",  32'(a_tx_data),   32'hFF);
    check("rst_tx_valid", 32'(a_tx_valid),  32'd0);
    check("rst_reg_wr",   32'(a_reg_wr),    32'd0);
    check("rst_reg_rd",   32'(b_reg_rd),    32'd0);
    check("rst_reg_addr", 32'(a_reg_addr),  32'd0);
    check("rst_err_code", 32'(b_err_code),  32'd0);
    check("rst_state",    32'(dut_a.state), 32'(ST_IDLE));
    rst_n = 1'b1;
    tick();

    // Single write 00 12 34 AB.
    wbase = a_wr_n; ebase = a_err_n;
    pulse_sof();
    send(8'h00); send(8'h12); send(8'h34);
    byte_in(8'hAB);
    check("wr_strobe", 32'(a_reg_wr),    32'd1);
    check("wr_addr",   32'(a_reg_addr),  32'h1234);
    check("wr_data",   32'(a_reg_wdata), 32'hAB);
    tick();
    check("wr_one_cycle", 32'(a_reg_wr), 32'd0);
    pulse_eof();
    check("wr_count", a_wr_n - wbase, 32'd1);
    check("wr_no_err", a_err_n - ebase, 32'd0);

    // Auto-increment burst wrapping FFFF -> 0000.
    wbase = a_wr_n;
    pulse_sof();
    send(8'h40); send(8'hFF); send(8'hFF); send(8'h01); send(8'h02);
    pulse_eof();
    check("burst_count", a_wr_n - wbase, 32'd2);
    check("burst_addr0", 32'(a_wr_addr[wbase]),     32'hFFFF);
    check("burst_data0", 32'(a_wr_data[wbase]),     32'h01);
    check("burst_addr1", 32'(a_wr_addr[wbase + 1]), 32'h0000);
    check("burst_data1", 32'(a_wr_data[wbase + 1]), 32'h02);

    // 16-bit read 80 00 10 returning BEEF, then a re-read of the same address.
    ebase = b_err_n;
    pulse_sof();
    send(8'h80); send(8'h00); send(8'h10);
    wait_b_rd("rd_strobe");
    check("rd_addr", 32'(b_reg_addr), 32'h0010);
    tick(); tick();
    reg_rdata = 16'hBEEF; reg_rvalid = 1'b1; tick(); reg_rvalid = 1'b0;
    flag_once();
    check("rd_tx_valid0", 32'(b_tx_valid), 32'd1);
    check("rd_tx_byte0",  32'(b_tx_data),  32'hBE);
    tick();
    check("rd_tx_valid_gap", 32'(b_tx_valid), 32'd0);
    flag_once();
    check("rd_tx_byte1",  32'(b_tx_data),  32'hEF);
    wait_b_rd("reread_strobe");
    check("reread_addr", 32'(b_reg_addr), 32'h0010);
    check("rd_no_err", b_err_n - ebase, 32'd0);
    pulse_eof();

    // Bad command 0x21 drops the frame; the next frame works.
    wbase = a_wr_n;
    pulse_sof();
    byte_in(8'h21);
    check("bad_err_pulse", 32'(a_err_pulse), 32'd1);
    check("bad_err_code",  32'(a_err_code),  32'(ERR_BAD_CMD));
    tick();
    check("bad_pulse_one_cycle", 32'(a_err_pulse), 32'd0);
    send(8'h00); send(8'h12); send(8'hAB);
    pulse_eof();
    check("bad_no_write", a_wr_n - wbase, 32'd0);
    pulse_sof();
    send(8'h00); send(8'h00); send(8'h05); send(8'h77);
    pulse_eof();
    check("recover_count", a_wr_n - wbase, 32'd1);
    check("recover_addr",  32'(a_wr_addr[wbase]), 32'h0005);
    check("recover_data",  32'(a_wr_data[wbase]), 32'h77);

    // Read timeout (RD_TIMEOUT=8) with an underrun flag during RD_WAIT.
    ebase = b_err_n;
    pulse_sof();
    send(8'h80); send(8'h00); send(8'h20);
    wait_b_rd("tmo_strobe");
    check("tmo_addr", 32'(b_reg_addr), 32'h0020);
    tick(); tick(); tick();
    flag_once();
    check("udr_err_pulse", 32'(b_err_pulse), 32'd1);
    check("udr_err_code",  32'(b_err_code),  32'(ERR_TX_UDR));
    check("udr_tx_valid",  32'(b_tx_valid),  32'd1);
    check("udr_tx_byte",   32'(b_tx_data),   32'hFF);
    tick(); tick(); tick();
    check("tmo_not_early", 32'(b_err_pulse), 32'd0);
    tick();
    check("tmo_err_pulse", 32'(b_err_pulse), 32'd1);
    check("tmo_err_code",  32'(b_err_code),  32'(ERR_RD_TMO));
    flag_once();
    check("tmo_tx_valid0", 32'(b_tx_valid), 32'd1);
    check("tmo_tx_byte0",  32'(b_tx_data),  32'hFF);
    tick();
    flag_once();
    check("tmo_tx_byte1",  32'(b_tx_data),  32'hFF);
    check("tmo_err_count", b_err_n - ebase, 32'd2);
    pulse_eof();

    // Short write: eof after 00 12.
    wbase = a_wr_n;
    pulse_sof();
    send(8'h00); send(8'h12);
    eof = 1'b1; tick(); eof = 1'b0;
    check("short_err_pulse", 32'(a_err_pulse), 32'd1);
    check("short_err_code",  32'(a_err_code),  32'(ERR_SHORT));
    tick();
    check("short_no_write", a_wr_n - wbase, 32'd0);

    // Flag outside a read: IDLE_BYTE, no error.
    flag_once();
    check("idle_tx_valid", 32'(a_tx_valid),  32'd1);
    check("idle_tx_byte",  32'(a_tx_data),   32'hFF);
    check("idle_no_err",   32'(a_err_pulse), 32'd0);
    tick();

    // Reset in the middle of a write frame.
    pulse_sof();
    send(8'h00); send(8'h12); send(8'h34);
    rst_n = 1'b0;
    #2;
    check("midrst_addr",     32'(a_reg_addr),  32'd0);
    check("midrst_tx_data",  32'(a_tx_data),   32'hFF);
    check("midrst_err_code", 32'(a_err_code),  32'd0);
    check("midrst_state",    32'(dut_a.state), 32'(ST_IDLE));
    check("midrst_b_code",   32'(b_err_code),  32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
